// File: rtl/prbs_gen_chk.sv
// Mode-selectable PRBS7/15/23/31 generator with a self-synchronising checker,
// lock/loss-of-lock tracking and a saturating error counter.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_FILL   | loading N received bits into the checker, no comparisons
// ST_HUNT   | counting consecutive matches towards lock, errors not counted
// ST_LOCKED | locked; mismatches counted, windowed loss-of-lock detection

module prbs_gen_chk #(
    parameter int CNT_W      = 16,
    parameter int LOCK_CNT   = 32,
    parameter int WIN        = 64,
    parameter int UNLOCK_ERR = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             inject_err,
    input  logic             rx_bit,
    input  logic             clr_cnt,
    output logic             tx_bit,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W  = $clog2(WIN + 1);
    localparam int WERR_W = $clog2(UNLOCK_ERR + 1);

    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WIN - 1);
    localparam logic [WERR_W-1:0] WERR_LAST = WERR_W'(UNLOCK_ERR - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t              state;
    logic [1:0]          mode_q;
    logic [30:0]         lfsr;
    logic [30:0]         chk;
    logic [4:0]          fill_cnt;
    logic [GOOD_W-1:0]   good_cnt;
    logic [WIN_W-1:0]    win_cnt;
    logic [WERR_W-1:0]   win_err;

    logic [4:0]          tap_n;
    logic [4:0]          tap_m;
    logic [30:0]         mask;
    logic                fb;
    logic                pred;
    logic                chk_zero;
    logic                mismatch;
    logic [30:0]         lfsr_nxt;
    logic [30:0]         chk_nxt;

    // Taps follow the registered mode so tx_bit stays a function of registers.
    always_comb begin
        tap_n = 5'd30;
        tap_m = 5'd27;
        mask  = 31'h7FFF_FFFF;
        case (mode_q)
            2'b00: begin tap_n = 5'd6;  tap_m = 5'd5;  mask = 31'h0000_007F; end
            2'b01: begin tap_n = 5'd14; tap_m = 5'd13; mask = 31'h0000_7FFF; end
            2'b10: begin tap_n = 5'd22; tap_m = 5'd17; mask = 31'h007F_FFFF; end
            default: begin tap_n = 5'd30; tap_m = 5'd27; mask = 31'h7FFF_FFFF; end
        endcase
    end

    assign fb       = lfsr[tap_n] ^ lfsr[tap_m];
    assign lfsr_nxt = {lfsr[29:0], fb} & mask;
    assign chk_nxt  = {chk[29:0], rx_bit} & mask;
    assign pred     = chk[tap_n] ^ chk[tap_m];
    // An all-zero history would otherwise predict 0 forever on a stuck-0 line.
    assign chk_zero = ((chk & mask) == 31'd0);
    assign mismatch = (pred != rx_bit) || chk_zero;
    assign tx_bit   = lfsr[tap_n] ^ (inject_err & en);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state     <= ST_FILL;
            mode_q    <= mode;
            lfsr      <= 31'd1;
            chk       <= '0;
            fill_cnt  <= '0;
            good_cnt  <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (mode != mode_q) begin
                state    <= ST_FILL;
                mode_q   <= mode;
                lfsr     <= 31'd1;
                chk      <= '0;
                fill_cnt <= '0;
                good_cnt <= '0;
                win_cnt  <= '0;
                win_err  <= '0;
                locked   <= 1'b0;
            end else if (en) begin
                lfsr <= lfsr_nxt;
                chk  <= chk_nxt;
                case (state)
                    ST_FILL: begin
                        if (fill_cnt == tap_n) begin
                            state    <= ST_HUNT;
                            fill_cnt <= '0;
                            good_cnt <= '0;
                        end else begin
                            fill_cnt <= fill_cnt + 5'd1;
                        end
                    end
                    ST_HUNT: begin
                        if (mismatch) begin
                            good_cnt <= '0;
                        end else if (good_cnt == GOOD_LAST) begin
                            state    <= ST_LOCKED;
                            locked   <= 1'b1;
                            good_cnt <= '0;
                            win_cnt  <= '0;
                            win_err  <= '0;
                        end else begin
                            good_cnt <= good_cnt + GOOD_W'(1);
                        end
                    end
                    ST_LOCKED: begin
                        if (mismatch) begin
                            err_pulse <= 1'b1;
                            if (err_cnt != CNT_MAX)
                                err_cnt <= err_cnt + CNT_W'(1);
                        end
                        // The error that causes the drop is still counted above.
                        if (mismatch && (win_err == WERR_LAST)) begin
                            state    <= ST_HUNT;
                            locked   <= 1'b0;
                            good_cnt <= '0;
                            win_cnt  <= '0;
                            win_err  <= '0;
                        end else if (win_cnt == WIN_LAST) begin
                            win_cnt <= '0;
                            win_err <= '0;
                        end else begin
                            win_cnt <= win_cnt + WIN_W'(1);
                            if (mismatch)
                                win_err <= win_err + WERR_W'(1);
                        end
                    end
                    default: begin
                        state  <= ST_FILL;
                        locked <= 1'b0;
                    end
                endcase
            end
            if (clr_cnt)
                err_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_prbs_gen_chk.sv
// Directed bench for prbs_gen_chk: reference PRBS model, lock timing, error
// injection offsets, saturation, clear, mode change, en gating and reset.

module tb_prbs_gen_chk;

    logic        clk = 1'b0;
    logic        rst_n, en, inject_err, clr_cnt;
    logic [1:0]  mode;
    logic [1:0]  rx_sel;
    logic        rx_bit, rx4;
    logic        tx_bit, locked, err_pulse;
    logic [15:0] err_cnt;
    logic        tx4, locked4, pulse4;
    logic [3:0]  err_cnt4;

    always #5 clk = ~clk;

    assign rx_bit = (rx_sel == 2'd0) ? tx_bit : (rx_sel == 2'd1) ? ~tx_bit : 1'b0;
    assign rx4    = (rx_sel == 2'd0) ? tx4    : (rx_sel == 2'd1) ? ~tx4    : 1'b0;

    prbs_gen_chk dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .inject_err(inject_err),
        .rx_bit(rx_bit), .clr_cnt(clr_cnt), .tx_bit(tx_bit), .locked(locked),
        .err_pulse(err_pulse), .err_cnt(err_cnt)
    );

    prbs_gen_chk #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .inject_err(inject_err),
        .rx_bit(rx4), .clr_cnt(clr_cnt), .tx_bit(tx4), .locked(locked4),
        .err_pulse(pulse4), .err_cnt(err_cnt4)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference Fibonacci PRBS, started from state 1
    logic [30:0] ref_lfsr;
    int          ref_n, ref_m;

    task automatic ref_reset(input logic [1:0] m);
        ref_lfsr = 31'd1;
        case (m)
            2'b00:   begin ref_n = 7;  ref_m = 6;  end
            2'b01:   begin ref_n = 15; ref_m = 14; end
            2'b10:   begin ref_n = 23; ref_m = 18; end
            default: begin ref_n = 31; ref_m = 28; end
        endcase
    endtask

    function automatic logic ref_bit();
        return ref_lfsr[ref_n-1];
    endfunction

    task automatic ref_adv();
        ref_lfsr = {ref_lfsr[29:0], ref_lfsr[ref_n-1] ^ ref_lfsr[ref_m-1]};
    endtask

    int smp, tx_errs, hold_errs, lock_first, pulse_n, locked_seen;
    int pulse_at[16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        smp = 0; tx_errs = 0; hold_errs = 0; lock_first = 0; pulse_n = 0; locked_seen = 0;
    endtask

    // n enabled samples; optional inject/clear at an absolute sample index; optional
    // idle (en=0) cycle before each sample.
    task automatic run(input int n, input int inj_at, input int clr_at, input bit toggle);
        for (int i = 0; i < n; i++) begin
            int s;
            s = smp + 1;
            if (toggle) begin
                en = 1'b0; inject_err = 1'b0; clr_cnt = 1'b0;
                #1;
                if (tx_bit !== ref_bit()) tx_errs++;
                tick();
                if (err_pulse !== 1'b0) hold_errs++;
            end
            en = 1'b1;
            inject_err = (s == inj_at);
            clr_cnt    = (s == clr_at);
            #1;
            if (tx_bit !== (ref_bit() ^ inject_err)) tx_errs++;
            tick();
            ref_adv();
            smp = s;
            if (err_pulse) begin
                if (pulse_n < 16) pulse_at[pulse_n] = s;
                pulse_n++;
            end
            if (locked && lock_first == 0) lock_first = s;
            if (locked) locked_seen = 1;
        end
        inject_err = 1'b0;
        clr_cnt    = 1'b0;
    endtask

    task automatic switch_mode(input logic [1:0] m, input string tag);
        mode = m; en = 1'b1; inject_err = 1'b0;
        tick();
        check_eq({tag, "_locked_after_switch"}, locked, 0);
        ref_reset(m);
        clear_stats();
    endtask

    task automatic inject_test(input string tag, input int exp_cnt);
        int k;
        pulse_n = 0;
        k = smp + 5;
        run(45, k, 0, 0);
        check_eq({tag, "_pulse_n"}, pulse_n, 3);
        check_eq({tag, "_pulse0"}, pulse_at[0], k);
        check_eq({tag, "_pulseM"}, pulse_at[1], k + ref_m);
        check_eq({tag, "_pulseN"}, pulse_at[2], k + ref_n);
        check_eq({tag, "_err_cnt"}, err_cnt, exp_cnt);
        check_eq({tag, "_locked"}, locked, 1);
    endtask

    task automatic clr_tick();
        en = 1'b0; clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; en = 1'b0; inject_err = 1'b0; clr_cnt = 1'b0;
        mode = 2'b11; rx_sel = 2'd0;
        tick(); tick();
        for (int m = 0; m < 4; m++) begin
            mode = m[1:0];
            tick();
            check_eq($sformatf("rst_tx_mode%0d", m), tx_bit, 0);
        end
        mode = 2'b11;
        tick();
        check_eq("rst_locked", locked, 0);
        check_eq("rst_err_pulse", err_pulse, 0);
        check_eq("rst_err_cnt", err_cnt, 0);

        // PRBS31 loopback, long run
        rst_n = 1'b0;
        ref_reset(2'b11);
        clear_stats();
        run(10063, 0, 0, 0);
        check_eq("p31_tx_seq", tx_errs, 0);
        check_eq("p31_lock_at", lock_first, 63);
        check_eq("p31_pulses", pulse_n, 0);
        check_eq("p31_err_cnt", err_cnt, 0);
        check_eq("p31_locked", locked, 1);

        inject_test("inj_m11", 3);

        switch_mode(2'b01, "m01");
        run(52, 0, 0, 0);
        check_eq("m01_tx_seq", tx_errs, 0);
        check_eq("m01_lock_at", lock_first, 47);
        check_eq("m01_err_cnt_held", err_cnt, 3);
        inject_test("inj_m01", 6);

        switch_mode(2'b00, "m00");
        run(44, 0, 0, 0);
        check_eq("m00_tx_seq", tx_errs, 0);
        check_eq("m00_lock_at", lock_first, 39);
        inject_test("inj_m00", 9);

        switch_mode(2'b10, "m10");
        run(60, 0, 0, 0);
        check_eq("m10_tx_seq", tx_errs, 0);
        check_eq("m10_lock_at", lock_first, 55);
        inject_test("inj_m10", 12);
        check_eq("inj_cnt4", err_cnt4, 12);

        // Saturation with the 4-bit counter instance
        clr_tick();
        check_eq("clr_cnt", err_cnt, 0);
        check_eq("clr_cnt4", err_cnt4, 0);
        pulse_n = 0;
        for (int j = 0; j < 6; j++) run(100, smp + 1, 0, 0);
        run(50, 0, 0, 0);
        check_eq("sat_pulses", pulse_n, 18);
        check_eq("sat_err_cnt", err_cnt, 18);
        check_eq("sat_err_cnt4", err_cnt4, 15);
        check_eq("sat_locked4", locked4, 1);
        clr_tick();
        check_eq("sat_clr4", err_cnt4, 0);
        begin
            int k;
            k = smp + 1;
            run(1, k, k, 0);
            check_eq("clr_vs_err_pulse", err_pulse, 1);
            check_eq("clr_vs_err_cnt", err_cnt, 0);
            run(40, 0, 0, 0);
            check_eq("clr_vs_err_tail", err_cnt, 2);
        end

        // Inverted line: every bit wrong
        clr_tick();
        switch_mode(2'b01, "inv");
        run(52, 0, 0, 0);
        check_eq("inv_pre_locked", locked, 1);
        rx_sel = 2'd1;
        pulse_n = 0;
        run(7, 0, 0, 0);
        check_eq("inv_locked_7", locked, 1);
        run(1, 0, 0, 0);
        check_eq("inv_locked_8", locked, 0);
        check_eq("inv_err_cnt_8", err_cnt, 8);
        run(100, 0, 0, 0);
        check_eq("inv_err_cnt_hold", err_cnt, 8);
        check_eq("inv_pulses", pulse_n, 8);
        check_eq("inv_locked_hold", locked, 0);

        // Stuck-0 line
        rx_sel = 2'd2;
        switch_mode(2'b11, "zero");
        run(300, 0, 0, 0);
        check_eq("zero_never_locked", locked_seen, 0);
        check_eq("zero_err_cnt", err_cnt, 8);

        // en toggling after reset
        rst_n = 1'b1; mode = 2'b11; en = 1'b0;
        tick();
        rst_n = 1'b0; rx_sel = 2'd0;
        ref_reset(2'b11);
        clear_stats();
        run(70, 0, 0, 1);
        check_eq("tog_tx_seq", tx_errs, 0);
        check_eq("tog_idle_pulse", hold_errs, 0);
        check_eq("tog_lock_at", lock_first, 63);

        // Reset mid-lock overrides clr, inject and mode change
        inject_test("pre_rst", 3);
        rst_n = 1'b1; en = 1'b1; inject_err = 1'b1; clr_cnt = 1'b1; mode = 2'b01;
        tick();
        rst_n = 1'b0; en = 1'b0; inject_err = 1'b0; clr_cnt = 1'b0;
        #1;
        check_eq("midrst_locked", locked, 0);
        check_eq("midrst_err_pulse", err_pulse, 0);
        check_eq("midrst_err_cnt", err_cnt, 0);
        check_eq("midrst_tx", tx_bit, 0);
        ref_reset(2'b01);
        clear_stats();
        run(60, 0, 0, 0);
        check_eq("midrst_tx_seq", tx_errs, 0);
        check_eq("midrst_lock_at", lock_first, 47);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/prbs_gen_chk.md
# prbs_gen_chk

Run-time-selectable PRBS generator and self-synchronising checker: PRBS7, PRBS15, PRBS23 or PRBS31 chosen by a mode input, one bit per enabled cycle. It is the successor to the fixed PRBS31 source/monitor pair. It adds error injection, a lock state machine, a saturating error counter and loss-of-lock detection. It sits between the chip pins and the bit-serial test datapath; tx_bit drives a pad and rx_bit comes from a pad or an internal loopback.

## Interface
- CNT_W, 16: error counter width.
- LOCK_CNT, 32: consecutive matching bits needed to declare lock.
- WIN, 64: loss-of-lock observation window, in sampled bits.
- UNLOCK_ERR, 8: errors within one window that force loss of lock.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-high reset (high = reset, despite the name).
- en  in  1  bit strobe: the generator advances and rx_bit is sampled only on cycles with en=1.
- mode  in  2  polynomial select:
  - 00: x^7+x^6+1 (N=7, M=6)
  - 01: x^15+x^14+1 (N=15, M=14)
  - 10: x^23+x^18+1 (N=23, M=18)
  - 11: x^31+x^28+1 (N=31, M=28)
- inject_err  in  1  inverts tx_bit in the current cycle when en=1.
- rx_bit  in  1  received serial bit.
- clr_cnt  in  1  synchronous clear of err_cnt.
- tx_bit  out  1  generated bit (combinational from registers: lfsr[N-1] ^ (inject_err & en)).
- locked  out  1  checker is in the LOCKED state.
- err_pulse  out  1  one-cycle pulse per counted error.
- err_cnt  out  CNT_W  saturating count of errors seen while LOCKED.

## Operation
- **Generator:** 31-bit lfsr; only bits [N-1:0] are active.
  - On en: lfsr[0] <= lfsr[N-1]^lfsr[M-1], lfsr[N-1:1] <= lfsr[N-2:0].
  - Reset value is 1.
- **Checker:** 31-bit chk shift register of received bits, chk[0] newest.
  - pred = chk[N-1]^chk[M-1].
  - On en: mismatch = (pred != rx_bit) OR (chk[N-1:0] == 0). The all-zero term prevents false lock on a stuck-0 line.
  - rx_bit is always shifted into chk, never pred (self-synchronising). A single line error therefore yields exactly 3 mismatches, at samples k, k+M and k+N.
- **FSM** states are FILL, HUNT and LOCKED; reset enters FILL with fill/good/window counters at 0.
  - FILL: count en samples; after N samples go to HUNT. No comparisons are made.
  - HUNT: good counter +1 on a match and cleared on a mismatch. When it reaches LOCK_CNT, go to LOCKED with window count and window-error count cleared. Mismatches in FILL or HUNT are never counted and never pulse.
  - LOCKED: each mismatch raises err_pulse, increments err_cnt (saturating at 2^CNT_W-1) and increments the window-error count.
    - If the window-error count reaches UNLOCK_ERR, go to HUNT (good counter cleared). The error that triggered the drop is counted.
    - After WIN samples the window and window-error counts restart at 0.
- **Mode change:** the registered mode is compared each cycle. On any change, lfsr reloads to 1, chk clears to 0, and the FSM returns to FILL with locked=0. err_cnt is held.
- **clr_cnt:** err_cnt <= 0. It takes priority over a same-cycle increment; err_pulse still fires.
- **en=0:** all state holds, err_pulse=0, tx_bit = lfsr[N-1].

## Timing
- Reset values:
  - lfsr=1, chk=0, FSM=FILL.
  - locked=0, err_pulse=0, err_cnt=0.
  - tx_bit = 0 for every mode.
- locked, err_pulse and err_cnt are registered.
  - They update on the edge that samples the bit concerned and are visible the following cycle.
  - err_pulse is one cycle wide per error.
- With continuous en and loopback (rx_bit = tx_bit), locked rises after exactly N+LOCK_CNT sampled bits:
  - PRBS31: 63
  - PRBS7: 39
- Reset asserted mid-operation overrides everything on that edge, including clr_cnt, inject_err and mode change.

## Test plan
- Loopback, mode=11, en=1 continuous → tx_bit sequence matches a reference x^31+x^28+1 model from lfsr=1. locked rises after bit 63. err_cnt stays 0 for 10,000 bits.
- Loopback locked in mode=00, one inject_err pulse at sample k → err_pulse at samples k, k+6 and k+7. err_cnt=3 and locked stays 1. Repeat for modes 01, 10 and 11 with offsets M and N.
- Locked, then rx_bit = ~tx_bit → error on every bit. locked drops after the 8th error, err_cnt=8, and err_cnt holds thereafter. With rx_bit tied to 0, locked never asserts.
- CNT_W=4: six inject pulses spaced 100 bits apart while locked → err_cnt=15 (saturated), locked stays 1. clr_cnt then gives 0. clr_cnt coincident with an error gives 0.
- Locked in mode=11, switch to mode=01 → next cycle locked=0 and tx_bit restarts the PRBS15 sequence from lfsr=1. Relock after 47 bits with err_cnt unchanged.
- en toggled 1/0 in loopback → identical bit sequence and lock at the 63rd enabled sample. rst_n pulsed mid-lock → all outputs return to reset values on the next cycle.
